// File: rtl/tx_circuit_scheduler_if.sv
// Queue-side and AXI-Stream handshake bundle between the circuit scheduler
// and the datapath that owns the per-destination FIFOs.
interface tx_circuit_scheduler_if #(
  parameter int NUM_QUEUES = 4
);
  localparam int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

  logic [NUM_QUEUES-1:0] q_empty;
  logic [NUM_QUEUES-1:0] q_head_tlast;
  logic [NUM_QUEUES-1:0] q_rd_en;
  logic [QW-1:0]         q_sel;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;

  modport master (
    input  q_empty,
    input  q_head_tlast,
    input  m_axis_tready,
    output q_rd_en,
    output q_sel,
    output m_axis_tvalid
  );

  modport slave (
    output q_empty,
    output q_head_tlast,
    output m_axis_tready,
    input  q_rd_en,
    input  q_sel,
    input  m_axis_tvalid
  );
endinterface

// File: rtl/tx_circuit_scheduler.sv
// Time-slotted circuit scheduler: each day serves one destination queue,
// whole packets only, then a night of reconfiguration rotates the circuit.
module tx_circuit_scheduler #(
  parameter int NUM_QUEUES   = 4,
  parameter int DAY_CYCLES   = 1024,
  parameter int NIGHT_CYCLES = 32,
  parameter int GUARD_CYCLES = 64
) (
  input  logic                          axi_aclk,
  input  logic                          reset,
  input  logic                          enable,
  tx_circuit_scheduler_if.master        bus,
  output logic                          night,
  output logic                          overrun,
  output logic [31:0]                   pkt_count
);

  localparam int QW   = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
  localparam int MAXC = (DAY_CYCLES > NIGHT_CYCLES) ? DAY_CYCLES : NIGHT_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  typedef enum logic [1:0] {
    S_NIGHT,
    S_IDLE,
    S_SEND
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] curq_q, curq_d;
  logic          overrun_q, overrun_d;
  logic [31:0]   pkt_q, pkt_d;

  logic          head_empty;
  logic          head_last;
  logic          tvalid;
  logic          beat;
  logic          day_end;
  logic          night_end;
  logic          guard_ok;
  logic [CW-1:0] cnt_sat;
  logic [QW-1:0] curq_next;

  assign head_empty = bus.q_empty[curq_q];
  assign head_last  = bus.q_head_tlast[curq_q];

  // Outputs are gated by reset so a mid-packet reset drops the stream at once.
  assign tvalid = !reset && (state_q == S_SEND) && !head_empty;
  assign beat   = tvalid && bus.m_axis_tready;

  assign day_end   = 32'(cnt_q) >= 32'(DAY_CYCLES - 1);
  assign night_end = 32'(cnt_q) >= 32'(NIGHT_CYCLES - 1);
  assign guard_ok  = (32'(cnt_q) + 32'(GUARD_CYCLES)) <= 32'(DAY_CYCLES);
  assign cnt_sat   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign curq_next = (curq_q == QW'(NUM_QUEUES - 1)) ? '0 : curq_q + 1'b1;

  always_comb begin
    bus.q_rd_en         = '0;
    bus.m_axis_tvalid   = tvalid;
    bus.q_rd_en[curq_q] = beat;
    bus.q_sel           = curq_q;
  end

  assign night     = reset || (state_q == S_NIGHT);
  assign overrun   = overrun_q;
  assign pkt_count = pkt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    curq_d    = curq_q;
    overrun_d = overrun_q;
    pkt_d     = pkt_q;
    unique case (state_q)
      S_NIGHT: begin
        if (night_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        cnt_d = cnt_sat;
        if (day_end) begin
          state_d = S_NIGHT;
          cnt_d   = '0;
          curq_d  = curq_next;
        end else if (enable && !head_empty && guard_ok) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        cnt_d = cnt_sat;
        if (beat && head_last) begin
          pkt_d = pkt_q + 32'd1;
          if (day_end) begin
            state_d = S_NIGHT;
            cnt_d   = '0;
            curq_d  = curq_next;
          end else begin
            state_d = S_IDLE;
          end
        end else if (day_end) begin
          // Packet still open at day end: keep sending, flag the spill.
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = S_NIGHT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      state_q   <= S_NIGHT;
      cnt_q     <= '0;
      curq_q    <= '0;
      overrun_q <= 1'b0;
      pkt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      curq_q    <= curq_d;
      overrun_q <= overrun_d;
      pkt_q     <= pkt_d;
    end
  end

endmodule

// File: tb/tb_tx_circuit_scheduler.sv
// Self-checking bench for tx_circuit_scheduler: fallthrough queue model,
// beat scoreboard, and per-scenario timing checks.
module tb_tx_circuit_scheduler;

  localparam int NQ    = 4;
  localparam int DAY   = 16;
  localparam int NIGHT = 4;
  localparam int GUARD = 6;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        night;
  logic        overrun;
  logic [31:0] pkt_count;

  tx_circuit_scheduler_if #(.NUM_QUEUES(NQ)) sif ();

  tx_circuit_scheduler #(
    .NUM_QUEUES  (NQ),
    .DAY_CYCLES  (DAY),
    .NIGHT_CYCLES(NIGHT),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .axi_aclk (clk),
    .reset    (reset),
    .enable   (enable),
    .bus      (sif),
    .night    (night),
    .overrun  (overrun),
    .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int q;
    bit last;
    int id;
  } beat_t;

  bit       lastm [NQ][256];
  int       idm   [NQ][256];
  bit [7:0] wr    [NQ];
  bit [7:0] pops  [NQ];
  bit       pop_pend [NQ];
  beat_t    sb[$];
  int       n_cmp;
  int       n_err;
  int       beats;
  int       next_id;

  always_comb begin
    sif.q_empty      = '1;
    sif.q_head_tlast = '0;
    for (int i = 0; i < NQ; i++) begin
      sif.q_empty[i]      = (wr[i] == pops[i]);
      sif.q_head_tlast[i] = lastm[i][pops[i]];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NQ; i++)
      if (pop_pend[i]) pops[i] <= pops[i] + 8'd1;
  end

  always @(negedge clk) begin
    beat_t e;
    for (int i = 0; i < NQ; i++) pop_pend[i] = 1'b0;
    if ($countones(sif.q_rd_en) > 1) begin
      n_cmp++; n_err++;
      $display("FAIL rd_en_onehot got=%b exp=at most one bit", sif.q_rd_en);
    end
    for (int i = 0; i < NQ; i++) begin
      if (sif.q_rd_en[i]) begin
        pop_pend[i] = 1'b1;
        beats++;
        n_cmp++;
        if (sif.m_axis_tready !== 1'b1 || sif.m_axis_tvalid !== 1'b1) begin
          n_err++;
          $display("FAIL rd_en_handshake q=%0d tvalid=%b tready=%b exp both 1", i, sif.m_axis_tvalid, sif.m_axis_tready);
        end
        n_cmp++;
        if (int'(sif.q_sel) != i) begin
          n_err++;
          $display("FAIL rd_en_vs_qsel got_qsel=%0d exp=%0d", sif.q_sel, i);
        end
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat q=%0d got=beat exp=none", i);
        end else begin
          e = sb.pop_front();
          if (e.q != i || e.id != idm[i][pops[i]] || e.last != lastm[i][pops[i]]) begin
            n_err++;
            $display("FAIL sb_beat got q=%0d id=%0d last=%0b exp q=%0d id=%0d last=%0b",
                     i, idm[i][pops[i]], lastm[i][pops[i]], e.q, e.id, e.last);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input int q, input int len);
    beat_t e;
    for (int b = 0; b < len; b++) begin
      lastm[q][wr[q]] = (b == len - 1);
      idm[q][wr[q]]   = next_id;
      e.q    = q;
      e.last = (b == len - 1);
      e.id   = next_id;
      sb.push_back(e);
      wr[q]  = wr[q] + 8'd1;
      next_id++;
    end
  endtask

  // Leaves reset asserted with the queue model flushed; caller releases it.
  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b1;
    sif.m_axis_tready = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < NQ; i++) wr[i] = pops[i];
    sb.delete();
    beats = 0;
  endtask

  task automatic test_reset();
    do_reset();
    push_pkt(0, 2);
    n_cmp++;
    if (night !== 1'b1 || sif.m_axis_tvalid !== 1'b0 || sif.q_rd_en !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outputs got night=%b tvalid=%b rd_en=%b exp 1/0/0000", night, sif.m_axis_tvalid, sif.q_rd_en);
    end
    n_cmp++;
    if (sif.q_sel !== 2'd0 || overrun !== 1'b0 || pkt_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_regs got q_sel=%0d overrun=%b pkt=%0d exp 0/0/0", sif.q_sel, overrun, pkt_count);
    end
  endtask

  task automatic test_idle_rotation();
    do_reset();
    reset = 1'b0;
    for (int k = 0; k < NIGHT; k++) begin
      n_cmp++;
      if (night !== 1'b1 || sif.m_axis_tvalid !== 1'b0) begin
        n_err++;
        $display("FAIL idle_night%0d got night=%b tvalid=%b exp 1/0", k, night, sif.m_axis_tvalid);
      end
      tick();
    end
    for (int k = 0; k < DAY; k++) begin
      n_cmp++;
      if (night !== 1'b0 || sif.q_sel !== 2'd0 || sif.m_axis_tvalid !== 1'b0) begin
        n_err++;
        $display("FAIL idle_day%0d got night=%b q_sel=%0d tvalid=%b exp 0/0/0", k, night, sif.q_sel, sif.m_axis_tvalid);
      end
      tick();
    end
    n_cmp++;
    if (night !== 1'b1 || sif.q_sel !== 2'd1) begin
      n_err++;
      $display("FAIL idle_rotate got night=%b q_sel=%0d exp 1/1", night, sif.q_sel);
    end
  endtask

  task automatic test_single_packet();
    do_reset();
    push_pkt(0, 3);
    reset = 1'b0;
    repeat (NIGHT) tick();
    n_cmp++;
    if (sif.m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL single_day0 got tvalid=%b exp 0", sif.m_axis_tvalid);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (sif.m_axis_tvalid !== 1'b1 || sif.q_rd_en !== 4'b0001) begin
        n_err++;
        $display("FAIL single_beat%0d got tvalid=%b rd_en=%b exp 1/0001", k, sif.m_axis_tvalid, sif.q_rd_en);
      end
      tick();
    end
    n_cmp++;
    if (sif.m_axis_tvalid !== 1'b0 || pkt_count !== 32'd1 || beats != 3 || sb.size() != 0) begin
      n_err++;
      $display("FAIL single_done got tvalid=%b pkt=%0d beats=%0d left=%0d exp 0/1/3/0",
               sif.m_axis_tvalid, pkt_count, beats, sb.size());
    end
  endtask

  task automatic test_guard();
    int early;
    do_reset();
    reset = 1'b0;
    repeat (NIGHT + 11) tick();
    push_pkt(0, 2);
    early = 0;
    for (int k = 0; k < 69; k++) begin
      if (sif.m_axis_tvalid === 1'b1) early++;
      tick();
    end
    n_cmp++;
    if (early != 0) begin
      n_err++;
      $display("FAIL guard_no_start got tvalid_cycles=%0d exp 0", early);
    end
    n_cmp++;
    if (sif.q_sel !== 2'd0 || night !== 1'b0) begin
      n_err++;
      $display("FAIL guard_slot got q_sel=%0d night=%b exp 0/0", sif.q_sel, night);
    end
    tick();
    n_cmp++;
    if (sif.m_axis_tvalid !== 1'b1 || sif.q_rd_en !== 4'b0001) begin
      n_err++;
      $display("FAIL guard_start got tvalid=%b rd_en=%b exp 1/0001", sif.m_axis_tvalid, sif.q_rd_en);
    end
    repeat (2) tick();
    n_cmp++;
    if (pkt_count !== 32'd1 || beats != 2) begin
      n_err++;
      $display("FAIL guard_done got pkt=%0d beats=%0d exp 1/2", pkt_count, beats);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    reset = 1'b0;
    repeat (NIGHT + 10) tick();
    push_pkt(0, 8);
    n_cmp++;
    if (sif.m_axis_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_latency got tvalid=%b exp 0", sif.m_axis_tvalid);
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (sif.m_axis_tvalid !== 1'b1 || night !== 1'b0 || sif.q_sel !== 2'd0 || overrun !== (k >= 5)) begin
        n_err++;
        $display("FAIL overrun_day%0d got tvalid=%b night=%b q_sel=%0d overrun=%b exp 1/0/0/%0b",
                 11 + k, sif.m_axis_tvalid, night, sif.q_sel, overrun, (k >= 5));
      end
      tick();
    end
    n_cmp++;
    if (night !== 1'b1 || sif.q_sel !== 2'd1 || overrun !== 1'b1 || pkt_count !== 32'd1 || beats != 8) begin
      n_err++;
      $display("FAIL overrun_end got night=%b q_sel=%0d overrun=%b pkt=%0d beats=%0d exp 1/1/1/1/8",
               night, sif.q_sel, overrun, pkt_count, beats);
    end
  endtask

  task automatic test_tlast_at_day_end();
    do_reset();
    reset = 1'b0;
    repeat (NIGHT + 10) tick();
    push_pkt(0, 5);
    tick();
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (sif.m_axis_tvalid !== 1'b1 || night !== 1'b0 || overrun !== 1'b0) begin
        n_err++;
        $display("FAIL edge_day%0d got tvalid=%b night=%b overrun=%b exp 1/0/0", 11 + k, sif.m_axis_tvalid, night, overrun);
      end
      tick();
    end
    n_cmp++;
    if (night !== 1'b1 || overrun !== 1'b0 || pkt_count !== 32'd1 || sif.q_sel !== 2'd1) begin
      n_err++;
      $display("FAIL edge_end got night=%b overrun=%b pkt=%0d q_sel=%0d exp 1/0/1/1", night, overrun, pkt_count, sif.q_sel);
    end
  endtask

  task automatic test_tready_toggle();
    int k;
    do_reset();
    push_pkt(0, 4);
    reset = 1'b0;
    repeat (NIGHT) tick();
    k = 0;
    while (pkt_count != 32'd1 && k < 40) begin
      sif.m_axis_tready = (k % 2 == 0);
      tick();
      k++;
    end
    sif.m_axis_tready = 1'b1;
    n_cmp++;
    if (pkt_count !== 32'd1 || beats != 4 || k != 9) begin
      n_err++;
      $display("FAIL tready_toggle got pkt=%0d pulses=%0d cycles=%0d exp 1/4/9", pkt_count, beats, k);
    end
  endtask

  task automatic test_enable_drop();
    int seq[$];
    int late;
    logic [1:0] prev;
    do_reset();
    push_pkt(0, 6);
    push_pkt(0, 2);
    reset = 1'b0;
    repeat (NIGHT + 3) tick();
    enable = 1'b0;
    prev = sif.q_sel;
    late = 0;
    for (int k = 0; k < 100 && seq.size() < 4; k++) begin
      tick();
      if (pkt_count == 32'd1 && sif.m_axis_tvalid === 1'b1) late++;
      if (sif.q_sel !== prev) seq.push_back(int'(sif.q_sel));
      prev = sif.q_sel;
    end
    n_cmp++;
    if (seq.size() != 4) begin
      n_err++;
      $display("FAIL enable_rotation_count got=%0d exp 4", seq.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_cmp++;
        if (seq[j] != (j + 1) % 4) begin
          n_err++;
          $display("FAIL enable_rotation%0d got q_sel=%0d exp %0d", j, seq[j], (j + 1) % 4);
        end
      end
    end
    n_cmp++;
    if (pkt_count !== 32'd1 || beats != 6 || late != 0 || sb.size() != 2 || sif.q_empty[0] !== 1'b0) begin
      n_err++;
      $display("FAIL enable_drop got pkt=%0d beats=%0d late=%0d left=%0d empty0=%b exp 1/6/0/2/0",
               pkt_count, beats, late, sb.size(), sif.q_empty[0]);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    push_pkt(0, 6);
    reset = 1'b0;
    repeat (NIGHT + 2) tick();
    n_cmp++;
    if (sif.m_axis_tvalid !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre got tvalid=%b exp 1", sif.m_axis_tvalid);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (sif.m_axis_tvalid !== 1'b0 || sif.q_rd_en !== 4'b0000 || night !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_out got tvalid=%b rd_en=%b night=%b exp 0/0000/1", sif.m_axis_tvalid, sif.q_rd_en, night);
    end
    tick();
    n_cmp++;
    if (beats != 1 || pkt_count !== 32'd0 || sif.q_sel !== 2'd0) begin
      n_err++;
      $display("FAIL midrst_state got beats=%0d pkt=%0d q_sel=%0d exp 1/0/0", beats, pkt_count, sif.q_sel);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    beats = 0;
    next_id = 0;
    reset = 1'b1;
    enable = 1'b1;
    sif.m_axis_tready = 1'b1;
    test_reset();
    test_idle_rotation();
    test_single_packet();
    test_guard();
    test_overrun();
    test_tlast_at_day_end();
    test_tready_toggle();
    test_enable_drop();
    test_reset_mid_packet();
    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
